// File: rtl/alu_seq_driver_if.sv
// Command and result handshake bundle for alu_seq_driver.
interface alu_seq_driver_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SEL_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [SEL_W-1:0] cmd_sel;
  logic [WIDTH-1:0] cmd_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;

  // Command issuer / result consumer side
  modport master (
    output cmd_valid, cmd_load, cmd_sel, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_load, cmd_sel, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/alu_seq_driver.sv
// Sequential initiator for the 4-bit combinational ALU: loads or executes
// commands against an internal accumulator and returns each result.
// Optional macro ALU_SEQ_CHECK_EN builds a reference ALU that flags a
// sticky chk_err when the sampled alu_y disagrees with the expected value.
module alu_seq_driver #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  alu_seq_driver_if.slave  bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] acc,
  output logic             chk_err
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             chk_err_q, chk_err_d;

`ifdef ALU_SEQ_CHECK_EN
  // Team ALU op table, used only to cross-check the external ALU
  function automatic logic [WIDTH-1:0] ref_y(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [SEL_W-1:0] sel
  );
    logic [WIDTH-1:0] y;
    y = '0;
    case (sel)
      SEL_W'(0): y = a & b;
      SEL_W'(1): y = a | b;
      SEL_W'(2): y = a + b;
      SEL_W'(3): y = '0;
      SEL_W'(4): y = a & ~b;
      SEL_W'(5): y = a | ~b;
      SEL_W'(6): y = a - b;
      SEL_W'(7): y = (a < b) ? WIDTH'(1) : '0;
      default:   y = '0;
    endcase
    return y;
  endfunction
`endif

  // State register and all datapath flops, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      cnt_q       <= '0;
      chk_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      cmd_ready_q <= cmd_ready_d;
      cnt_q       <= cnt_d;
      chk_err_q   <= chk_err_d;
    end
  end

  // Next-state and datapath updates; every register holds by default
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    cmd_ready_d = cmd_ready_q;
    cnt_d       = cnt_q;
    chk_err_d   = chk_err_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (bus.cmd_load) begin
            acc_d       = bus.cmd_b;
            res_data_d  = bus.cmd_b;
            res_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            alu_a_d   = acc_q;
            alu_b_d   = bus.cmd_b;
            alu_sel_d = bus.cmd_sel;
            cnt_d     = CNT_W'(SETTLE - 1);
            state_d   = DRIVE;
          end
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CAPTURE: begin
        acc_d       = alu_y;
        res_data_d  = alu_y;
        res_valid_d = 1'b1;
        state_d     = RESP;
`ifdef ALU_SEQ_CHECK_EN
        if (alu_y != ref_y(alu_a_q, alu_b_q, alu_sel_q)) begin
          chk_err_d = 1'b1;
        end
`endif
      end
      RESP: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_sel       = alu_sel_q;
  assign acc           = acc_q;
`ifdef ALU_SEQ_CHECK_EN
  assign chk_err       = chk_err_q;
`else
  assign chk_err       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_driver.sv
// Bench for alu_seq_driver: SETTLE=1 and SETTLE=4 instances against a
// behavioural ALU and an accumulator model.
module tb_alu_seq_driver;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  alu_seq_driver_if #(.WIDTH(4), .SEL_W(3)) if1 ();
  alu_seq_driver_if #(.WIDTH(4), .SEL_W(3)) if4 ();

  logic [3:0] alu_a1, alu_b1, alu_y1, acc1;
  logic [2:0] alu_sel1;
  logic       chk_err1;
  logic [3:0] alu_a4, alu_b4, alu_y4, acc4;
  logic [2:0] alu_sel4;
  logic       chk_err4;
  logic       fault_en = 1'b0;
  logic       glitch4  = 1'b0;

  alu_seq_driver #(.WIDTH(4), .SEL_W(3), .SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1), .alu_y(alu_y1),
    .acc(acc1), .chk_err(chk_err1)
  );

  alu_seq_driver #(.WIDTH(4), .SEL_W(3), .SETTLE(4)) dut4 (
    .clk(clk), .reset(reset), .bus(if4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_sel(alu_sel4), .alu_y(alu_y4),
    .acc(acc4), .chk_err(chk_err4)
  );

  // Behavioural ALU from the op table, plain arithmetic on integers
  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] sel);
    int ai, bi, r;
    ai = int'(a);
    bi = int'(b);
    case (sel)
      3'd0: r = ai & bi;
      3'd1: r = ai | bi;
      3'd2: r = (ai + bi) % 16;
      3'd3: r = 0;
      3'd4: r = ai & (15 - bi);
      3'd5: r = ai | (15 - bi);
      3'd6: r = (ai - bi + 16) % 16;
      default: r = (ai < bi) ? 1 : 0;
    endcase
    return 4'(r);
  endfunction

  always_comb begin
    if (fault_en && alu_sel1 == 3'b010 && alu_a1 == 4'd1 && alu_b1 == 4'd1)
      alu_y1 = 4'd0;
    else
      alu_y1 = alu_ref(alu_a1, alu_b1, alu_sel1);
  end

  assign alu_y4 = glitch4 ? ~alu_ref(alu_a4, alu_b4, alu_sel4)
                          : alu_ref(alu_a4, alu_b4, alu_sel4);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Model of the DUT1 architectural state
  logic [3:0] m_acc, m_a, m_b;
  logic [2:0] m_sel;

  task automatic model_reset();
    m_acc = '0; m_a = '0; m_b = '0; m_sel = '0;
  endtask

  // Issue one command to DUT1 and check the full response; called at #1 after posedge
  task automatic send1(input logic ld, input logic [2:0] sel, input logic [3:0] b,
                       input logic [3:0] exp, input int stall, input bit hold_valid);
    int n;
    int lat;
    n = 0;
    while (!if1.cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("ready_timeout", 1, 0);
    if1.cmd_valid = 1'b1;
    if1.cmd_load  = ld;
    if1.cmd_sel   = sel;
    if1.cmd_b     = b;
    @(posedge clk); #1;
    if1.cmd_valid = 1'b0;
    if1.cmd_load  = 1'($urandom);
    if1.cmd_sel   = 3'($urandom);
    if1.cmd_b     = 4'($urandom);
    chk("cmd_ready_low", int'(if1.cmd_ready), 0);
    lat = 0;
    while (!if1.res_valid && lat < 40) begin
      if1.res_ready = 1'($urandom);
      @(posedge clk); #1; lat++;
    end
    if1.res_ready = 1'b0;
    chk("latency", lat, ld ? 0 : 2);
    chk("res_data", int'(if1.res_data), int'(exp));
    chk("acc", int'(acc1), int'(exp));
    if (hold_valid) if1.cmd_valid = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_valid", int'(if1.res_valid), 1);
      chk("stall_data", int'(if1.res_data), int'(exp));
      chk("stall_acc", int'(acc1), int'(exp));
      chk("stall_ready", int'(if1.cmd_ready), 0);
    end
    if1.cmd_valid = 1'b0;
    if1.res_ready = 1'b1;
    @(posedge clk); #1;
    if1.res_ready = 1'b0;
    chk("valid_drop", int'(if1.res_valid), 0);
    chk("idle_ready", int'(if1.cmd_ready), 1);
  endtask

  // Apply one command to the model, then to DUT1, and check ALU-side outputs
  task automatic run1(input logic ld, input logic [2:0] sel, input logic [3:0] b,
                      input int stall, input bit hold_valid);
    logic [3:0] exp;
    if (ld) begin
      exp = b;
    end else begin
      m_a = m_acc; m_b = b; m_sel = sel;
      exp = alu_ref(m_a, m_b, m_sel);
      if (fault_en && sel == 3'b010 && m_a == 4'd1 && b == 4'd1) exp = 4'd0;
    end
    m_acc = exp;
    send1(ld, sel, b, exp, stall, hold_valid);
    chk("alu_a", int'(alu_a1), int'(m_a));
    chk("alu_b", int'(alu_b1), int'(m_b));
    chk("alu_sel", int'(alu_sel1), int'(m_sel));
  endtask

  typedef struct {
    logic [2:0] sel;
    logic [3:0] exp;
  } chain_t;
  chain_t tbl[8];

  int exp_chk;

  initial begin
    tbl[0] = '{3'b000, 4'b0000};
    tbl[1] = '{3'b001, 4'b1111};
    tbl[2] = '{3'b010, 4'b1111};
    tbl[3] = '{3'b011, 4'b0000};
    tbl[4] = '{3'b100, 4'b1000};
    tbl[5] = '{3'b101, 4'b1000};
    tbl[6] = '{3'b110, 4'b0001};
    tbl[7] = '{3'b111, 4'b0000};
`ifdef ALU_SEQ_CHECK_EN
    exp_chk = 1;
`else
    exp_chk = 0;
`endif

    {if1.cmd_valid, if1.cmd_load, if1.cmd_sel, if1.cmd_b, if1.res_ready} = '0;
    {if4.cmd_valid, if4.cmd_load, if4.cmd_sel, if4.cmd_b, if4.res_ready} = '0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_ready", int'(if1.cmd_ready), 1);
    chk("rst_valid", int'(if1.res_valid), 0);
    chk("rst_acc", int'(acc1), 0);
    chk("rst_alu", int'({alu_a1, alu_b1, alu_sel1}), 0);
    chk("rst_chk", int'(chk_err1), 0);
    chk("rst4_ready", int'(if4.cmd_ready), 1);

    // Load then add
    run1(1'b1, 3'b000, 4'b1000, 0, 1'b0);
    run1(1'b0, 3'b010, 4'b0111, 0, 1'b0);

    // Every op against A=1000, B=0111, table driven
    for (int i = 0; i < 8; i++) begin
      run1(1'b1, 3'b000, 4'b1000, 0, 1'b0);
      chk($sformatf("tbl_model_%0d", i), int'(alu_ref(4'b1000, 4'b0111, tbl[i].sel)),
          int'(tbl[i].exp));
      run1(1'b0, tbl[i].sel, 4'b0111, 0, 1'b0);
      chk($sformatf("tbl_res_%0d", i), int'(acc1), int'(tbl[i].exp));
    end

    // Backpressure: 5-cycle stall with a competing command held valid
    run1(1'b0, 3'b001, 4'b0011, 5, 1'b1);
    run1(1'b1, 3'b000, 4'b0101, 5, 1'b1);

    // Randomised traffic against the model
    for (int i = 0; i < 60; i++) begin
      run1(($urandom % 4) == 0, 3'($urandom), 4'($urandom),
           int'($urandom % 4), 1'($urandom));
    end
    chk("rand_chk", int'(chk_err1), 0);

    // SETTLE=4: load A=0011, then SEL=110 B=0101; alu_y is only correct before E0+5
    if4.cmd_valid = 1'b1; if4.cmd_load = 1'b1; if4.cmd_b = 4'b0011;
    @(posedge clk); #1;
    if4.cmd_valid = 1'b0;
    chk("s4_load_valid", int'(if4.res_valid), 1);
    if4.res_ready = 1'b1;
    @(posedge clk); #1;
    if4.res_ready = 1'b0;
    if4.cmd_valid = 1'b1; if4.cmd_load = 1'b0; if4.cmd_sel = 3'b110; if4.cmd_b = 4'b0101;
    @(posedge clk); #1;
    if4.cmd_valid = 1'b0; if4.cmd_b = 4'b1111; if4.cmd_sel = 3'b000;
    for (int k = 1; k <= 6; k++) begin
      glitch4 = (k != 5);
      @(posedge clk); #1;
      chk($sformatf("s4_valid_e%0d", k), int'(if4.res_valid), (k >= 5) ? 1 : 0);
    end
    glitch4 = 1'b0;
    chk("s4_res", int'(if4.res_data), 14);
    chk("s4_acc", int'(acc4), 14);
    chk("s4_chk", int'(chk_err4), 0);
    if4.res_ready = 1'b1;
    @(posedge clk); #1;
    if4.res_ready = 1'b0;
    chk("s4_idle", int'(if4.cmd_ready), 1);

    // Faulty ALU: 1+1 returns 0
    fault_en = 1'b1;
    run1(1'b1, 3'b000, 4'b0001, 0, 1'b0);
    run1(1'b0, 3'b010, 4'b0001, 0, 1'b0);
    chk("chk_err_set", int'(chk_err1), exp_chk);
    fault_en = 1'b0;
    run1(1'b0, 3'b001, 4'b0010, 1, 1'b0);
    chk("chk_err_sticky", int'(chk_err1), exp_chk);

    // Reset during DRIVE drops the command
    if1.cmd_valid = 1'b1; if1.cmd_load = 1'b0; if1.cmd_sel = 3'b010; if1.cmd_b = 4'b0011;
    @(posedge clk); #1;
    if1.cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("mid_rst_ready", int'(if1.cmd_ready), 1);
    chk("mid_rst_valid", int'(if1.res_valid), 0);
    chk("mid_rst_acc", int'(acc1), 0);
    chk("mid_rst_data", int'(if1.res_data), 0);
    chk("mid_rst_alu", int'({alu_a1, alu_b1, alu_sel1}), 0);
    chk("mid_rst_chk", int'(chk_err1), 0);
    if1.res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("dropped_no_resp", int'(if1.res_valid), 0);
    end
    if1.res_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_driver.md
Name: alu_seq_driver

Overview:
- Sequential initiator for the team's 4-bit combinational ALU (A, B, SEL in; Y out).
- Accepts operation commands over a valid/ready handshake, drives the ALU operands with A taken from an internal accumulator, waits a fixed settle time, captures Y into the accumulator and returns it over a valid/ready result port.
- Replaces hand-written stimulus sequences when the ALU is used inside clocked datapaths.

Parameters:
- WIDTH, 4, operand/result width in bits.
- SEL_W, 3, ALU opcode width.
- SETTLE, 1, cycles the ALU inputs are held before Y is sampled; legal range 1..15.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_load  input  1  1 = load accumulator with cmd_b; 0 = execute ALU op.
- cmd_sel  input  SEL_W  ALU opcode.
- cmd_b  input  WIDTH  B operand, or load value.
- alu_a  output  WIDTH  to ALU A (registered).
- alu_b  output  WIDTH  to ALU B (registered).
- alu_sel  output  SEL_W  to ALU SEL (registered).
- alu_y  input  WIDTH  from ALU Y.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  WIDTH  result value.
- acc  output  WIDTH  current accumulator.
- chk_err  output  1  sticky check error (see Optional Feature).

Behaviour:
- Reset (synchronous, highest priority, also mid-operation): state=IDLE; acc, alu_a, alu_b, alu_sel, res_data = 0; res_valid=0; chk_err=0; settle counter=0. Any in-flight command is dropped with no response.
- FSM states: IDLE, DRIVE, CAPTURE, RESP.
- IDLE: cmd_ready=1. Ready is low in all other states, so only one command is outstanding.
- Accept in IDLE (cmd_valid & cmd_ready at edge E0):
  - cmd_load=1: acc<=cmd_b, res_data<=cmd_b, go RESP. res_valid is high in the cycle after E0. ALU outputs are unchanged.
  - cmd_load=0: alu_a<=acc, alu_b<=cmd_b, alu_sel<=cmd_sel, counter<=SETTLE-1, go DRIVE.
- DRIVE: ALU inputs held stable. When counter==0, go CAPTURE; otherwise decrement.
- CAPTURE: acc<=alu_y, res_data<=alu_y, go RESP. alu_y is sampled exactly SETTLE+1 edges after E0.
- Op latency: res_valid rises SETTLE+2 cycles after E0. With SETTLE=1, res_valid is high in cycle E0+3.
- RESP: res_valid=1. res_data is held until res_valid & res_ready. On that edge: res_valid<=0, go IDLE. The next command can be accepted on the following edge.
- Backpressure:
  - res_data, acc and the ALU outputs are stable while res_valid=1 and res_ready=0, for unbounded stall.
  - res_ready while res_valid=0 is ignored.
- Inputs cmd_sel, cmd_b and cmd_load are sampled only on the accept edge. Changes at other times have no effect.
- Arithmetic: the block does no arithmetic itself. acc wraps naturally at WIDTH bits because it takes the ALU result.
- acc is output combinationally from its register at all times.

Optional Feature:
- Macro: ALU_SEQ_CHECK_EN.
- Defined: an internal reference model computes the expected Y from the registered alu_a, alu_b and alu_sel using the team ALU op table:
  - 000 A&B
  - 001 A|B
  - 010 A+B (mod 2^WIDTH)
  - 011 0
  - 100 A&~B
  - 101 A|~B
  - 110 A-B (mod 2^WIDTH)
  - 111 (A<B unsigned) ? 1 : 0
- In CAPTURE, if alu_y differs from the expected value, chk_err<=1. chk_err is sticky until reset. The result is still captured from alu_y.
- Not defined: no model is built and chk_err is tied 0.

Test Plan:
- Load then add: reset; load B=1000 → res_data=1000, acc=1000. Op SEL=010, B=0111, with a behavioural ALU → alu_a=1000, alu_b=0111; res_data=1111 at E0+3 (SETTLE=1); acc=1111.
- Chaining all ops: load 1000, then SEL 000..111 each with B=0111 and acc re-loaded to 1000 before each op → results 0000, 1111, 1111, 0000, 1000, 1000, 0001, 0000. cmd_ready is low from E0+1 until the response handshake.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid → res_valid, res_data and acc are stable. No new command is accepted even with cmd_valid=1. On release, IDLE follows the next cycle.
- Settle timing: SETTLE=4, op SEL=110, A=0011, B=0101 → res_data=1110. res_valid first high at E0+6. The ALU model's output is only sampled at E0+5.
- Reset mid-op: assert reset during DRIVE → next cycle all outputs are 0, cmd_ready=1, and no res_valid ever appears for the dropped command.
- Check (ALU_SEQ_CHECK_EN): inject a faulty ALU returning 0000 for SEL=010 with A=0001, B=0001 → chk_err=1 after CAPTURE and stays 1. Without the macro, chk_err stays 0.
